// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises, debounces and polarity-normalises external
// reset sources, merges them with a software request, enforces a minimum
// hold time, then releases the stage resets in order (bit 0 first) with a
// fixed delay between stages. Any request re-asserts every stage at once.
// Optional macro RESET_SEQ_CAUSE_EN adds a sticky reset-cause register
// (reset_cause output, cause_clear input).
module reset_sequencer #(
    parameter int                     NUM_SOURCES     = 2,
    parameter logic [NUM_SOURCES-1:0] SRC_ACTIVE_LOW  = '0,
    parameter int                     DEBOUNCE_CYCLES = 16,
    parameter int                     HOLD_CYCLES     = 10,
    parameter int                     NUM_STAGES      = 3,
    parameter int                     STAGE_DELAY     = 8
) (
    input  logic                   clk_0,
    input  logic                   por_reset,
    input  logic [NUM_SOURCES-1:0] reset_src,
    input  logic                   sw_reset,
`ifdef RESET_SEQ_CAUSE_EN
    input  logic                   cause_clear,
    output logic [NUM_SOURCES:0]   reset_cause,
`endif
    output logic [NUM_STAGES-1:0]  reset_out,
    output logic                   all_released
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int DLY_W  = $clog2(STAGE_DELAY + 1);
    localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    logic [NUM_SOURCES-1:0] sync1_q;
    logic [NUM_SOURCES-1:0] sync2_q;
    logic [NUM_SOURCES-1:0] norm;
    logic [NUM_SOURCES-1:0] deb;
    logic                   req;

    state_e                 state_q;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic [DLY_W-1:0]       dly_cnt_q;
    logic [IDX_W-1:0]       stage_idx_q;
    logic [NUM_STAGES-1:0]  reset_out_q;
    logic                   all_rel_q;
    logic [NUM_STAGES-1:0]  stage_bit;

    // Two-flop synchroniser for the asynchronous reset sources
    always_ff @(posedge clk_0) begin
        if (por_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= reset_src;
            sync2_q <= sync1_q;
        end
    end

    // After normalisation a 1 always means "source requests reset"
    assign norm = sync2_q ^ SRC_ACTIVE_LOW;

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_deb
            logic [DEB_W-1:0] cnt_q;
            logic             deb_q;

            // Debounced level only follows norm after DEBOUNCE_CYCLES unbroken cycles of disagreement
            always_ff @(posedge clk_0) begin
                if (por_reset) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else if (norm[gi] == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DEB_LAST) begin
                    deb_q <= norm[gi];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign deb[gi] = deb_q;
        end
    endgenerate

    assign req       = (|deb) | sw_reset;
    assign stage_bit = NUM_STAGES'(1) << stage_idx_q;

    // Sequencing FSM: a request from any state wins over every release step
    always_ff @(posedge clk_0) begin
        if (por_reset || req) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            dly_cnt_q   <= '0;
            stage_idx_q <= '0;
            reset_out_q <= '1;
            all_rel_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q     <= ST_RELEASE;
                        hold_cnt_q  <= '0;
                        dly_cnt_q   <= '0;
                        stage_idx_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (dly_cnt_q == DLY_LAST) begin
                        dly_cnt_q   <= '0;
                        reset_out_q <= reset_out_q & ~stage_bit;
                        if (stage_idx_q == IDX_LAST) begin
                            state_q   <= ST_RUN;
                            all_rel_q <= 1'b1;
                        end else begin
                            stage_idx_q <= stage_idx_q + 1'b1;
                        end
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    all_rel_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_HOLD;
                    reset_out_q <= '1;
                    all_rel_q   <= 1'b0;
                end
            endcase
        end
    end

    assign reset_out    = reset_out_q;
    assign all_released = all_rel_q;

`ifdef RESET_SEQ_CAUSE_EN
    logic [NUM_SOURCES:0] cause_q;

    // Sticky record of which requests interrupted a release or running system
    always_ff @(posedge clk_0) begin
        if (por_reset) begin
            cause_q <= '0;
        end else if (req && (state_q == ST_RELEASE || state_q == ST_RUN)) begin
            cause_q <= cause_q | {sw_reset, deb};
        end else if (cause_clear) begin
            cause_q <= '0;
        end
    end

    assign reset_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer. Two instances
// share stimulus; instance B uses SRC_ACTIVE_LOW=2'b10 and sees source 1
// inverted, so both must match one reference model. The model predicts
// outputs from "edges since last request" arithmetic. Cause checks are
// active when RESET_SEQ_CAUSE_EN is defined.
module tb_reset_sequencer;

    localparam int          NS     = 2;
    localparam int          D      = 16;
    localparam int          H      = 10;
    localparam int          S      = 3;
    localparam int          SD     = 8;
    localparam logic [1:0]  MASK_B = 2'b10;

    logic       clk = 1'b0;
    logic       por;
    logic       sw;
    logic       cclr;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] ro_a, ro_b;
    logic       ar_a, ar_b;
    logic [2:0] cause_a, cause_b;

    assign src_b = src_a ^ MASK_B;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_SOURCES(NS), .SRC_ACTIVE_LOW(2'b00), .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H), .NUM_STAGES(S), .STAGE_DELAY(SD)
    ) u_dut_a (
        .clk_0(clk), .por_reset(por), .reset_src(src_a), .sw_reset(sw),
`ifdef RESET_SEQ_CAUSE_EN
        .cause_clear(cclr), .reset_cause(cause_a),
`endif
        .reset_out(ro_a), .all_released(ar_a)
    );

    reset_sequencer #(
        .NUM_SOURCES(NS), .SRC_ACTIVE_LOW(MASK_B), .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H), .NUM_STAGES(S), .STAGE_DELAY(SD)
    ) u_dut_b (
        .clk_0(clk), .por_reset(por), .reset_src(src_b), .sw_reset(sw),
`ifdef RESET_SEQ_CAUSE_EN
        .cause_clear(cclr), .reset_cause(cause_b),
`endif
        .reset_out(ro_b), .all_released(ar_b)
    );

`ifndef RESET_SEQ_CAUSE_EN
    assign cause_a = '0;
    assign cause_b = '0;
`endif

    typedef struct packed {
        logic [2:0] ro;
        logic       ar;
        logic [2:0] cause;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state (written only by the stimulus process)
    logic [1:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
    logic [2:0] m_cause = '0;
    int         m_run[2] = '{0, 0};
    int         m_n = 0;

    // Predict the outputs after the coming edge from the inputs it will sample
    task automatic model_step();
        exp_t       e;
        logic       req;
        logic [2:0] ones;
        int         k;
        ones = '1;
        if (por) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_cause = '0;
            m_run[0] = 0; m_run[1] = 0; m_n = 0;
            e.ro = '1; e.ar = 1'b0;
        end else begin
            req = (|m_deb) | sw;
            // Outside HOLD means at least H quiet edges have already elapsed
            if (req && m_n >= H) m_cause = m_cause | {sw, m_deb};
            else if (cclr)       m_cause = '0;
            if (req) m_n = 0;
            else if (m_n < H + S * SD) m_n++;
            k = (m_n >= H) ? (m_n - H) / SD : 0;
            if (k > S) k = S;
            e.ro = ones << k;
            e.ar = (k == S);
            for (int i = 0; i < NS; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = src_a;
        end
        e.cause = m_cause;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic p, input logic [1:0] s, input logic w, input logic c);
        @(negedge clk);
        por = p; src_a = s; sw = w; cclr = c;
        model_step();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic hold_src(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, s, 1'b0, 1'b0);
    endtask

    // Monitor: one expectation per edge, compared 1 time unit after the edge
    initial begin
        exp_t       e;
        logic [2:0] last_ro = 3'bxxx;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests++;
                if (ro_a !== e.ro || ar_a !== e.ar) begin
                    fails++;
                    $display("FAIL out_a t=%0t: got reset_out=%b all_released=%b, expected %b %b",
                             $time, ro_a, ar_a, e.ro, e.ar);
                end
                tests++;
                if (ro_b !== e.ro || ar_b !== e.ar) begin
                    fails++;
                    $display("FAIL out_b t=%0t: got reset_out=%b all_released=%b, expected %b %b",
                             $time, ro_b, ar_b, e.ro, e.ar);
                end
`ifdef RESET_SEQ_CAUSE_EN
                tests++;
                if (cause_a !== e.cause || cause_b !== e.cause) begin
                    fails++;
                    $display("FAIL cause t=%0t: got a=%b b=%b, expected %b",
                             $time, cause_a, cause_b, e.cause);
                end
`endif
                if (e.ro !== last_ro)
                    $display("[TB] t=%0t reset_out=%b all_released=%b cause=%b",
                             $time, e.ro, e.ar, e.cause);
                last_ro = e.ro;
            end
        end
    end

    initial begin
        int kind;
        int len;
        por = 1'b1; src_a = '0; sw = 1'b0; cclr = 1'b0;

        // Reset, then a clean release sequence into RUN
        for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 1'b0, 1'b0);
        quiet(45);
        // Short glitch in RUN must be filtered
        hold_src(2'b01, 10);
        quiet(20);
        // Long source assertion, then recovery
        hold_src(2'b01, 30);
        quiet(70);
        // sw pulse in RUN, then another one after stage 0 released
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        quiet(H + SD + 2);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        quiet(60);
        // Source 1 (active-low on instance B) keeps both in HOLD
        hold_src(2'b10, 50);
        quiet(70);
        // Cause capture, clear, and simultaneous clear with capture
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        quiet(50);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        quiet(50);
        drive(1'b0, 2'b00, 1'b1, 1'b1);
        quiet(5);
        // sw coincident with the final stage release
        quiet(H + S * SD - 1 - 5);
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        quiet(5);

        // Randomised segments
        for (int seg = 0; seg < 60; seg++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: quiet($urandom_range(1, 60));
                1: begin
                    len = $urandom_range(1, 3);
                    for (int i = 0; i < len; i++) drive(1'b0, 2'b00, 1'b1, 1'($urandom_range(0, 1)));
                end
                2: hold_src(2'($urandom_range(1, 3)), $urandom_range(1, D - 1));
                3: hold_src(2'($urandom_range(1, 3)), $urandom_range(D, D + 30));
                4: begin
                    len = $urandom_range(1, 3);
                    for (int i = 0; i < len; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
                end
                5: drive(1'b0, 2'b00, 1'b0, 1'b1);
                default: begin
                    for (int i = 0; i < 20; i++)
                        drive(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
                              1'($urandom_range(0, 7) == 0));
                end
            endcase
            quiet($urandom_range(0, 45));
        end

        @(posedge clk);
        #3;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
